// File: rtl/pipe_reg_elastic.sv
// Elastic inter-stage pipeline register: valid/ready handshake, optional 2-entry skid buffer,
// flush/freeze controls and saturating stall/bubble counters.
module pipe_reg_elastic #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SKID  = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             freeze,
    input  logic             clr_cnt,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    logic main_valid;
    logic skid_valid;
    logic accept;
    logic emit;
    logic stall_inc;
    logic bubble_inc;

    // Handshake decode. With SKID=1 in_ready depends only on the state flop and the two
    // control inputs, so out_ready never reaches in_ready combinationally.
    always_comb begin
        main_valid = (state_q != ST_EMPTY);
        skid_valid = (state_q == ST_TWO);
        if (SKID != 0) begin
            in_ready = ~skid_valid & ~freeze & ~flush;
        end else begin
            in_ready = (~main_valid | out_ready) & ~freeze & ~flush;
        end
        out_valid = main_valid & ~freeze;
        accept    = in_valid & in_ready;
        // A beat shown during flush is discarded, not delivered.
        emit      = out_valid & out_ready & ~flush;
    end

    // Next-state and datapath: flush beats freeze beats normal operation.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through the case
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else if (!freeze) begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        main_d = in_data;
                    end else if (accept) begin
                        // Only reachable with the skid buffer present; SKID=0 accepts while
                        // full only when the held beat leaves in the same cycle.
                        if (SKID != 0) begin
                            state_d = ST_TWO;
                            skid_d  = in_data;
                        end
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (emit) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Performance counters: clear wins over increment, increments stop at all-ones.
    always_comb begin
        stall_inc  = out_valid & ~out_ready & ~flush;
        bubble_inc = out_ready & ~out_valid & ~freeze & ~flush;
        stall_d    = stall_q;
        bubble_d   = bubble_q;
        if (clr_cnt) begin
            stall_d  = '0;
            bubble_d = '0;
        end else begin
            if (stall_inc && (stall_q != CNT_MAX)) begin
                stall_d = stall_q + CNT_ONE;
            end
            if (bubble_inc && (bubble_q != CNT_MAX)) begin
                bubble_d = bubble_q + CNT_ONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of block ordering.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ST_EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    always_comb begin
        unique case (state_q)
            ST_ONE:  occupancy = 2'd1;
            ST_TWO:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign out_data   = main_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Scoreboard bench for pipe_reg_elastic: a SKID=1 main instance, a CNT_W=2 instance and a
// SKID=0 instance share one stimulus stream; each scenario task checks its own instance.
module tb_pipe_reg_elastic;

    logic       CLK;
    logic       nRST;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       flush;
    logic       freeze;
    logic       clr_cnt;

    logic        s1_in_ready, s1_out_valid;
    logic [7:0]  s1_out_data;
    logic [1:0]  s1_occupancy;
    logic [15:0] s1_stall, s1_bubble;

    logic        c2_in_ready, c2_out_valid;
    logic [7:0]  c2_out_data;
    logic [1:0]  c2_occupancy;
    logic [1:0]  c2_stall, c2_bubble;

    logic        s0_in_ready, s0_out_valid;
    logic [7:0]  s0_out_data;
    logic [1:0]  s0_occupancy;
    logic [15:0] s0_stall, s0_bubble;

    int checks   = 0;
    int failures = 0;
    int emit_cnt = 0;
    logic [7:0] sb_q[$];
    logic [7:0] sb_exp;

    pipe_reg_elastic #(.WIDTH(8), .SKID(1), .CNT_W(16)) u_s1 (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(s1_in_ready), .in_data(in_data),
        .out_valid(s1_out_valid), .out_ready(out_ready), .out_data(s1_out_data), .flush(flush),
        .freeze(freeze), .clr_cnt(clr_cnt), .occupancy(s1_occupancy), .stall_cnt(s1_stall),
        .bubble_cnt(s1_bubble)
    );

    pipe_reg_elastic #(.WIDTH(8), .SKID(1), .CNT_W(2)) u_c2 (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(c2_in_ready), .in_data(in_data),
        .out_valid(c2_out_valid), .out_ready(out_ready), .out_data(c2_out_data), .flush(flush),
        .freeze(freeze), .clr_cnt(clr_cnt), .occupancy(c2_occupancy), .stall_cnt(c2_stall),
        .bubble_cnt(c2_bubble)
    );

    pipe_reg_elastic #(.WIDTH(8), .SKID(0), .CNT_W(16)) u_s0 (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(s0_in_ready), .in_data(in_data),
        .out_valid(s0_out_valid), .out_ready(out_ready), .out_data(s0_out_data), .flush(flush),
        .freeze(freeze), .clr_cnt(clr_cnt), .occupancy(s0_occupancy), .stall_cnt(s0_stall),
        .bubble_cnt(s0_bubble)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard on the main instance: sampled mid-cycle, reflecting the handshake
    // that completes on the following rising edge.
    always @(negedge CLK) begin
        if (!nRST || flush) begin
            sb_q.delete();
        end else begin
            if (s1_out_valid && out_ready) begin
                emit_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_beat got=%h expected no beat", s1_out_data);
                end else begin
                    sb_exp = sb_q.pop_front();
                    if (s1_out_data !== sb_exp) begin
                        failures++;
                        $display("FAIL sb_order got=%h exp=%h", s1_out_data, sb_exp);
                    end
                end
            end
            if (in_valid && s1_in_ready) sb_q.push_back(in_data);
        end
    end

    task automatic apply_reset();
        in_valid = 0; in_data = 0; out_ready = 0; flush = 0; freeze = 0; clr_cnt = 0;
        nRST = 0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1;
        #1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_data = 0; out_ready = 0; flush = 0; freeze = 0; clr_cnt = 0;
        nRST = 0;
        #3;
        checks++; if (s1_occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", s1_occupancy); end
        checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", s1_out_valid); end
        checks++; if (s1_out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", s1_out_data); end
        checks++; if (s1_stall !== 16'd0 || s1_bubble !== 16'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", s1_stall, s1_bubble); end
        checks++; if (s1_in_ready !== 1'b1 || s0_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b/%b exp=1/1", s1_in_ready, s0_in_ready); end
        repeat (2) @(posedge CLK);
        #1 nRST = 1;
        #1;
    endtask

    task automatic test_stream();
        int base;
        apply_reset();
        base = emit_cnt;
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'hA0 + 8'(i);
            @(posedge CLK); #1;
            checks++;
            if (s1_out_valid !== 1'b1 || s1_out_data !== 8'hA0 + 8'(i)) begin
                failures++; $display("FAIL stream_data[%0d] got=%b/%h exp=1/%h", i, s1_out_valid, s1_out_data, 8'hA0 + 8'(i));
            end
            checks++; if (s1_occupancy !== 2'd1) begin failures++; $display("FAIL stream_occupancy[%0d] got=%0d exp=1", i, s1_occupancy); end
        end
        in_valid = 0;
        @(posedge CLK); #1;
        checks++; if (emit_cnt - base !== 8) begin failures++; $display("FAIL stream_emits got=%0d exp=8", emit_cnt - base); end
        checks++; if (s1_stall !== 16'd0) begin failures++; $display("FAIL stream_stall got=%0d exp=0", s1_stall); end
        checks++; if (s1_occupancy !== 2'd0) begin failures++; $display("FAIL stream_drained got=%0d exp=0", s1_occupancy); end
    endtask

    task automatic test_backpressure();
        int base;
        apply_reset();
        base = emit_cnt;
        out_ready = 0; in_valid = 1; in_data = 8'h11;
        @(posedge CLK); #1;
        in_data = 8'h22;
        #1;
        checks++; if (s1_in_ready !== 1'b1 || s1_occupancy !== 2'd1) begin failures++; $display("FAIL bp_one got=%b/%0d exp=1/1", s1_in_ready, s1_occupancy); end
        @(posedge CLK); #1;
        in_data = 8'h33;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            checks++;
            if (s1_in_ready !== 1'b0 || s1_occupancy !== 2'd2 || s1_out_data !== 8'h11) begin
                failures++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h exp=0/2/11", k, s1_in_ready, s1_occupancy, s1_out_data);
            end
        end
        checks++; if (s1_stall !== 16'd4) begin failures++; $display("FAIL bp_stall got=%0d exp=4", s1_stall); end
        out_ready = 1;
        #1;
        checks++; if (s1_in_ready !== 1'b0) begin failures++; $display("FAIL bp_release_ready got=%b exp=0", s1_in_ready); end
        @(posedge CLK); #1;
        checks++; if (s1_out_data !== 8'h22 || s1_in_ready !== 1'b1) begin failures++; $display("FAIL bp_skid_move got=%h/%b exp=22/1", s1_out_data, s1_in_ready); end
        @(posedge CLK); #1;
        in_valid = 0;
        checks++; if (s1_out_data !== 8'h33) begin failures++; $display("FAIL bp_third got=%h exp=33", s1_out_data); end
        @(posedge CLK); #1;
        checks++; if (emit_cnt - base !== 3 || s1_occupancy !== 2'd0) begin failures++; $display("FAIL bp_drain got=%0d/%0d exp=3/0", emit_cnt - base, s1_occupancy); end
        checks++; if (s1_stall !== 16'd4) begin failures++; $display("FAIL bp_stall_final got=%0d exp=4", s1_stall); end
    endtask

    task automatic test_flush();
        int base;
        apply_reset();
        out_ready = 0; in_valid = 1; in_data = 8'h44;
        @(posedge CLK); #1;
        in_data = 8'h66;
        @(posedge CLK); #1;
        checks++; if (s1_occupancy !== 2'd2) begin failures++; $display("FAIL flush_fill got=%0d exp=2", s1_occupancy); end
        in_data = 8'h55; flush = 1;
        #1;
        checks++; if (s1_in_ready !== 1'b0 || s1_out_valid !== 1'b1) begin failures++; $display("FAIL flush_cycle got=%b/%b exp=0/1", s1_in_ready, s1_out_valid); end
        @(posedge CLK); #1;
        flush = 0; in_valid = 0;
        #1;
        checks++;
        if (s1_out_valid !== 1'b0 || s1_occupancy !== 2'd0 || s1_out_data !== 8'h00) begin
            failures++; $display("FAIL flush_after got=%b/%0d/%h exp=0/0/00", s1_out_valid, s1_occupancy, s1_out_data);
        end
        checks++; if (s1_stall !== 16'd1) begin failures++; $display("FAIL flush_stall got=%0d exp=1", s1_stall); end
        base = emit_cnt;
        out_ready = 1;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (emit_cnt !== base) begin failures++; $display("FAIL flush_no_emit got=%0d exp=%0d", emit_cnt, base); end
    endtask

    task automatic test_freeze();
        int base;
        apply_reset();
        out_ready = 0; in_valid = 1; in_data = 8'h77;
        @(posedge CLK); #1;
        in_data = 8'h99; freeze = 1; out_ready = 1;
        #1;
        checks++; if (s1_out_valid !== 1'b0 || s1_in_ready !== 1'b0) begin failures++; $display("FAIL freeze_comb got=%b/%b exp=0/0", s1_out_valid, s1_in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            checks++;
            if (s1_occupancy !== 2'd1 || s1_out_data !== 8'h77 || s1_out_valid !== 1'b0 || s1_in_ready !== 1'b0) begin
                failures++; $display("FAIL freeze_hold[%0d] got=%0d/%h/%b/%b exp=1/77/0/0", k, s1_occupancy, s1_out_data, s1_out_valid, s1_in_ready);
            end
        end
        checks++; if (s1_stall !== 16'd0 || s1_bubble !== 16'd0) begin failures++; $display("FAIL freeze_counters got=%0d/%0d exp=0/0", s1_stall, s1_bubble); end
        base = emit_cnt;
        freeze = 0; in_valid = 0;
        #1;
        checks++; if (s1_out_valid !== 1'b1 || s1_out_data !== 8'h77) begin failures++; $display("FAIL freeze_release got=%b/%h exp=1/77", s1_out_valid, s1_out_data); end
        @(posedge CLK); #1;
        checks++; if (emit_cnt - base !== 1 || s1_occupancy !== 2'd0) begin failures++; $display("FAIL freeze_emit got=%0d/%0d exp=1/0", emit_cnt - base, s1_occupancy); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_b;
        apply_reset();
        out_ready = 1; in_valid = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge CLK); #1;
            exp_b = (k > 3) ? 2'd3 : 2'(k);
            checks++; if (c2_bubble !== exp_b) begin failures++; $display("FAIL sat_bubble[%0d] got=%0d exp=%0d", k, c2_bubble, exp_b); end
        end
        checks++; if (s1_bubble !== 16'd5) begin failures++; $display("FAIL wide_bubble got=%0d exp=5", s1_bubble); end
        clr_cnt = 1;
        @(posedge CLK); #1;
        clr_cnt = 0;
        checks++; if (c2_bubble !== 2'd0 || s1_bubble !== 16'd0) begin failures++; $display("FAIL clr_cnt got=%0d/%0d exp=0/0", c2_bubble, s1_bubble); end
    endtask

    task automatic test_skid0();
        apply_reset();
        out_ready = 0; in_valid = 1; in_data = 8'hC1;
        @(posedge CLK); #1;
        in_data = 8'hC2;
        #1;
        checks++; if (s0_in_ready !== 1'b0 || s0_occupancy !== 2'd1 || s0_out_data !== 8'hC1) begin failures++; $display("FAIL s0_full got=%b/%0d/%h exp=0/1/c1", s0_in_ready, s0_occupancy, s0_out_data); end
        out_ready = 1;
        #1;
        checks++; if (s0_in_ready !== 1'b1) begin failures++; $display("FAIL s0_ready_comb got=%b exp=1", s0_in_ready); end
        @(posedge CLK); #1;
        checks++; if (s0_out_data !== 8'hC2 || s0_occupancy !== 2'd1 || s0_out_valid !== 1'b1) begin failures++; $display("FAIL s0_reload got=%h/%0d/%b exp=c2/1/1", s0_out_data, s0_occupancy, s0_out_valid); end
        in_data = 8'hC3;
        @(posedge CLK); #1;
        checks++; if (s0_out_data !== 8'hC3) begin failures++; $display("FAIL s0_stream got=%h exp=c3", s0_out_data); end
        #2 nRST = 0;
        #1;
        checks++; if (s0_out_valid !== 1'b0 || s0_occupancy !== 2'd0 || s0_out_data !== 8'h00) begin failures++; $display("FAIL s0_async_reset got=%b/%0d/%h exp=0/0/00", s0_out_valid, s0_occupancy, s0_out_data); end
        checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("FAIL s1_async_reset got=%b exp=0", s1_out_valid); end
        apply_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nRST = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_freeze();
        test_saturate();
        test_skid0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_reg_elastic.md
Name: pipe_reg_elastic

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque WIDTH-bit payload bundle between two pipeline stages.
- Uses a valid/ready handshake with an optional 2-entry skid buffer that breaks the ready path.
- Keeps flush and freeze controls, and adds saturating back-pressure and bubble performance counters.

Parameters:
- WIDTH, 32: payload width in bits (>=1).
- SKID, 1: 1 = 2-entry skid buffer with in_ready taken from flops only; 0 = single register with in_ready combinational from out_ready.
- CNT_W, 16: width of each performance counter (>=2).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  downstream payload (oldest entry).
- flush  in  1  discard all held entries.
- freeze  in  1  hold all state, block both handshakes.
- clr_cnt  in  1  synchronous clear of both counters.
- occupancy  out  2  entries held (0..2; never exceeds 1 when SKID=0).
- stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready.
- bubble_cnt  out  CNT_W  cycles with out_ready & ~out_valid & ~freeze & ~flush.

Behaviour:
- Reset (nRST low, asynchronous):
  - all entries invalid; main and skid data = 0; state EMPTY.
  - occupancy = 0, out_valid = 0, out_data = 0, both counters = 0.
  - in_ready follows its equation, so it is 1 while freeze and flush are low.
  - Reset mid-transfer discards all entries with no further handshake.
- Handshakes:
  - Accept when in_valid & in_ready. Emit when out_valid & out_ready.
  - Order is strictly FIFO. Data never changes while out_valid=1 and out_ready=0.
- Priority, per cycle: flush > freeze > normal.
- flush:
  - forces in_ready = 0; the offered beat is dropped and not acknowledged.
  - out_valid is still shown, but the flushed entry is not counted as emitted.
  - Next edge: all entries invalid, data regs = 0, state EMPTY.
  - Counters do not increment in a flush cycle.
- freeze (flush low):
  - in_ready = 0 and out_valid = 0; data, state and occupancy are held.
  - Counters hold. out_data still shows the main entry.
- SKID=1 state machine (main register + skid register):
  - in_ready = ~skid_valid & ~freeze & ~flush (flop-derived only).
  - out_valid = main_valid & ~freeze. out_data = main.
  - EMPTY: accept -> ONE (main <= in_data).
  - ONE:
    - accept & emit -> ONE (main <= in_data).
    - accept & ~emit -> TWO (skid <= in_data).
    - emit & ~accept -> EMPTY.
    - neither -> ONE.
  - TWO: in_ready = 0.
    - emit -> ONE (main <= skid; skid cleared).
    - otherwise -> hold.
  - Full-throughput streaming at 1 beat/cycle in the ONE state.
- SKID=0:
  - in_ready = (~main_valid | out_ready) & ~freeze & ~flush.
  - Accept loads main; emit without accept clears main_valid.
  - Simultaneous accept and emit reloads main.
- Counters:
  - saturate at 2^CNT_W-1; no wrap.
  - clr_cnt zeroes both counters next edge. clr_cnt has priority over increment and is independent of flush.
- Latency: in_data accepted at edge N appears on out_data after edge N when the stage was empty. Minimum latency is 1 cycle; there is no combinational data bypass.

Test Plan:
- SKID=1: reset, then stream 0xA0..0xA7 with in_valid=1 and out_ready=1 -> out_data A0..A7 on 8 consecutive cycles, 1-cycle latency, occupancy=1, stall_cnt=0.
- SKID=1: hold out_ready=0 while offering 0x11, 0x22, 0x33 -> 0x11 and 0x22 accepted, in_ready=0 with occupancy=2. Release out_ready -> 0x11, 0x22, 0x33 emitted in order. stall_cnt = cycles held.
- flush asserted with occupancy=2 and in_valid=1 (0x55) -> in_ready=0; next cycle out_valid=0, occupancy=0, out_data=0; 0x55 is never emitted.
- freeze for 3 cycles while occupancy=1 (0x77) and out_ready=1 -> out_valid=0, in_ready=0, counters unchanged. On release, 0x77 is emitted the next cycle.
- CNT_W=2: out_ready=1 and in_valid=0 for 5 cycles -> bubble_cnt saturates at 3. Then clr_cnt=1 -> 0.
- SKID=0: out_ready=0 with main full -> in_ready=0. Raise out_ready -> in_ready=1 the same cycle, with simultaneous accept and emit. Async nRST low mid-stream -> out_valid=0 immediately.
